vreg_serial_seq: RTL and testbench

Sequencer that drives the serial element port of the 8x16x16-bit vector register file, moving one whole vector between the register file and the scalar data memory. A load copies 16 consecutive memory words into a vector register via WR_s; a store reads a vector register via RD_s and writes 16 consecutive memory words. The block sits between the vector load/store decode and both the register file's serial port and the data-memory port, and it generates the strobe pattern that the register file's element counter expects.

---
 rtl/vreg_serial_seq.sv | 121 ++++++++++++
 tb/tb_vreg_serial_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vreg_serial_seq.sv
// rtl/vreg_serial_seq.sv - moves one whole vector between the vector register
// file serial port and data memory (load: mem->vreg, store: vreg->mem).
module vreg_serial_seq #(
   parameter int DATA_W  = 16,
   parameter int MADDR_W = 16,
   parameter int NELEM   = 16
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               op_i,
   input  logic [2:0]         vaddr_i,
   input  logic [MADDR_W-1:0] mem_base_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2:0]         addr_o,
   output logic               wr_s_o,
   output logic               rd_s_o,
   output logic [DATA_W-1:0]  data_in_s_o,
   input  logic [DATA_W-1:0]  data_out_s_i,
   output logic [MADDR_W-1:0] mem_addr_o,
   output logic               mem_rd_o,
   output logic               mem_wr_o,
   output logic [DATA_W-1:0]  mem_wdata_o,
   input  logic [DATA_W-1:0]  mem_rdata_i
);

   localparam int CNT_W = $clog2(NELEM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic               op_q, op_d;
   logic [2:0]         addr_q, addr_d;
   logic [MADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic               lag_q, lag_d;
   logic [CNT_W-1:0]   lag_k_q, lag_k_d;
   logic [MADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic               stream;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         op_q       <= 1'b0;
         addr_q     <= '0;
         base_q     <= '0;
         k_q        <= '0;
         lag_q      <= 1'b0;
         lag_k_q    <= '0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         base_q     <= base_d;
         k_q        <= k_d;
         lag_q      <= lag_d;
         lag_k_q    <= lag_k_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      base_d  = base_q;
      k_d     = k_q;
      // The second side of the transfer trails the first by one cycle.
      lag_d   = (state_q == S_STREAM);
      lag_k_d = k_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d    = op_i;
               addr_d  = vaddr_i;
               base_d  = mem_base_i;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            k_d     = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            k_d = k_q + CNT_W'(1);
            if (k_q == CNT_W'(NELEM - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stream   = (state_q == S_STREAM);
      mem_rd_o = stream & ~op_q;
      rd_s_o   = stream & op_q;
      wr_s_o   = lag_q & ~op_q;
      mem_wr_o = lag_q & op_q;
      // Address holds its last value whenever no memory strobe is active.
      mem_addr_o = mem_addr_q;
      if (mem_rd_o)      mem_addr_o = base_q + MADDR_W'(k_q);
      else if (mem_wr_o) mem_addr_o = base_q + MADDR_W'(lag_k_q);
      mem_addr_d = mem_addr_o;
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign addr_o      = addr_q;
   assign data_in_s_o = mem_rdata_i;
   assign mem_wdata_o = data_out_s_i;

endmodule

// File: tb/tb_vreg_serial_seq.sv
// tb/tb_vreg_serial_seq.sv - directed bench for vreg_serial_seq with register
// file and data memory models.
module tb_vreg_serial_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [2:0]  vaddr;
   logic [15:0] mem_base;
   logic        busy, done, wr_s, rd_s, mem_rd, mem_wr;
   logic [2:0]  addr;
   logic [15:0] data_in_s, data_out_s, mem_addr, mem_wdata, mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] mem [0:65535];
   logic [15:0] vec [0:7][0:15];
   logic [3:0]  idx;
   logic        tb_we;
   logic [15:0] tb_wa, tb_wd;

   vreg_serial_seq dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .op_i         (op),
      .vaddr_i      (vaddr),
      .mem_base_i   (mem_base),
      .busy_o       (busy),
      .done_o       (done),
      .addr_o       (addr),
      .wr_s_o       (wr_s),
      .rd_s_o       (rd_s),
      .data_in_s_o  (data_in_s),
      .data_out_s_i (data_out_s),
      .mem_addr_o   (mem_addr),
      .mem_rd_o     (mem_rd),
      .mem_wr_o     (mem_wr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file serial port: element index advances on every strobed cycle.
   always @(posedge clk) begin
      if (wr_s) vec[addr][idx] <= data_in_s;
      if (rd_s) data_out_s <= vec[addr][idx];
      if (wr_s || rd_s) idx <= idx + 4'd1;
      else              idx <= 4'd0;
   end

   always @(posedge clk) begin
      if (tb_we)       mem[tb_wa] <= tb_wd;
      else if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic c_op, input logic [2:0] c_va, input logic [15:0] c_base,
                          input bit pulses, input bit hold);
      logic [5:0]  exp_ctl;
      logic [15:0] ea;
      bit          first, lag;
      op = c_op; vaddr = c_va; mem_base = c_base; start = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (!hold) start = 1'b0;
         if (pulses && (t == 5 || t == 18)) begin
            start = 1'b1; op = ~c_op; vaddr = 3'd7; mem_base = 16'h0000;
         end
         first   = (t >= 2 && t <= 17);
         lag     = (t >= 3 && t <= 18);
         exp_ctl = {(t >= 1 && t <= 19), (t == 19), first & ~c_op, lag & ~c_op,
                    first & c_op, lag & c_op};
         chk($sformatf("ctl t%0d", t), 32'({busy, done, mem_rd, wr_s, rd_s, mem_wr}), 32'(exp_ctl));
         if (t >= 1 && t <= 19) chk($sformatf("addr t%0d", t), 32'(addr), 32'(c_va));
         if (!c_op && first) begin
            ea = c_base + 16'(t - 2);
            chk($sformatf("maddr ld t%0d", t), 32'(mem_addr), 32'(ea));
         end
         if (c_op && lag) begin
            ea = c_base + 16'(t - 3);
            chk($sformatf("maddr st t%0d", t), 32'(mem_addr), 32'(ea));
         end
         if (t == 19) begin
            ea = c_base + 16'd15;
            chk("maddr hold", 32'(mem_addr), 32'(ea));
         end
      end
   endtask

   initial begin
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
      rst_n = 1'b0;
      start = 1'($urandom); op = 1'($urandom); vaddr = 3'($urandom);
      mem_base = 16'($urandom);
      tick(); tick(); tick();
      chk("rst ctl", 32'({busy, done, mem_rd, wr_s, rd_s, mem_wr}), 32'd0);
      chk("rst addr", 32'(addr), 32'd0);
      chk("rst maddr", 32'(mem_addr), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post rst busy", 32'(busy), 32'd0);

      for (int k = 0; k < 16; k++) begin
         tb_we = 1'b1;
         tb_wa = 16'h0100 + 16'(k); tb_wd = 16'hA000 + 16'(k); tick();
         tb_wa = 16'h0500 + 16'(k); tb_wd = 16'h1234 + 16'(k); tick();
         tb_wa = 16'h0200 + 16'(k); tb_wd = 16'h0F0F + 16'(k) * 16'h0101; tick();
      end
      tb_we = 1'b0;
      tick();

      // Load with spurious Start pulses while busy.
      run_cmd(1'b0, 3'd3, 16'h0100, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("vreg3[%0d]", k), 32'(vec[3][k]), 32'(16'hA000 + 16'(k)));

      // Store crossing the top of memory.
      run_cmd(1'b0, 3'd5, 16'h0500, 1'b0, 1'b0);
      run_cmd(1'b1, 3'd5, 16'hFFF8, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("wrap mem[%0d]", k), 32'(mem[16'hFFF8 + 16'(k)]), 32'(16'h1234 + 16'(k)));

      // Round trip, back to back with Start held through the first command.
      run_cmd(1'b0, 3'd2, 16'h0200, 1'b0, 1'b1);
      run_cmd(1'b1, 3'd2, 16'h0300, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("rt mem[%0d]", k), 32'(mem[16'h0300 + 16'(k)]),
             32'(16'h0F0F + 16'(k) * 16'h0101));

      // Reset in the middle of a store.
      op = 1'b1; vaddr = 3'd5; mem_base = 16'h0400; start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 2; t <= 10; t++) tick();
      chk("pre rst rd_s", 32'(rd_s), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid rst ctl", 32'({busy, done, mem_rd, wr_s, rd_s, mem_wr}), 32'd0);
      chk("mid rst addr", 32'(addr), 32'd0);
      chk("mid rst maddr", 32'(mem_addr), 32'd0);
      tick(); tick();
      chk("mid rst done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();
      run_cmd(1'b0, 3'd6, 16'h0100, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++)
         chk($sformatf("vreg6[%0d]", k), 32'(vec[6][k]), 32'(16'hA000 + 16'(k)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
